rv32i_dmem_responder: RTL and testbench

Data-memory responder for the RV32i pipeline: serves the load/store requests the control path issues from the MEM stage (`dmem_re`/`dmem_we`) with configurable wait states. While an access is in progress it drives the pipeline's exec/mem stall input. Loads are sign- or zero-extended and stores are byte-lane masked per RV32I func3. It replaces the zero-latency data RAM so that the pipeline's stall paths are exercised.

---
 rtl/rv32i_dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for the RV32I MEM stage.
// Serves loads/stores with a fixed number of wait states and stalls the pipe.
module rv32i_dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        dmem_re_i,
    input  logic        dmem_we_i,
    input  logic [31:0] dmem_add_i,
    input  logic [31:0] dmem_di_i,
    input  logic [2:0]  dmem_func3_i,
    output logic [31:0] dmem_do_o,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH+1:0] req_add;
    logic [31:0]           req_di;
    logic [2:0]            req_f3;
    logic                  req_re;
    logic                  req_we;

    logic [31:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic                  bad_f3;
    logic                  misalign;
    logic                  req_err;
    logic                  commit;
    logic                  do_write;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           ld_val;
    logic [31:0]           wr_word;
    logic                  addr_unused;

    // Upper address bits alias; they are deliberately dropped.
    assign addr_unused = ^dmem_add_i[31:ADDR_WIDTH+2];

    assign idx    = req_add[ADDR_WIDTH+1:2];
    assign lane   = req_add[1:0];
    assign commit = (state == BUSY) && (cnt == 4'd0);

    always_comb begin
        bad_f3 = 1'b0;
        if (req_we) begin
            bad_f3 = req_f3[2] | (req_f3[1:0] == 2'd3);
        end else begin
            bad_f3 = (req_f3 == 3'd3) | (req_f3[2:1] == 2'b11);
        end
    end

    always_comb begin
        misalign = 1'b0;
        if (req_f3[1:0] == 2'd1) begin
            misalign = lane[0];
        end else if (req_f3[1:0] == 2'd2) begin
            misalign = (lane != 2'd0);
        end
    end

    assign req_err  = (req_re & req_we) | bad_f3 | misalign;
    assign do_write = commit & req_we & ~req_err;

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_val = rd_word;
        case (req_f3)
            3'd0:    ld_val = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    ld_val = {{16{rd_half[15]}}, rd_half};
            3'd4:    ld_val = {24'd0, rd_byte};
            3'd5:    ld_val = {16'd0, rd_half};
            default: ld_val = rd_word;
        endcase
    end

    // Read-modify-write merge: untouched lanes keep their old contents.
    always_comb begin
        wr_word = rd_word;
        case (req_f3[1:0])
            2'd0: wr_word[{lane, 3'b000} +: 8] = req_di[7:0];
            2'd1: begin
                if (lane[1]) begin
                    wr_word[31:16] = req_di[15:0];
                end else begin
                    wr_word[15:0] = req_di[15:0];
                end
            end
            default: wr_word = req_di;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_add   <= '0;
            req_di    <= '0;
            req_f3    <= '0;
            req_re    <= 1'b0;
            req_we    <= 1'b0;
            dmem_do_o <= '0;
            err_o     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (dmem_re_i | dmem_we_i) begin
                        req_add <= dmem_add_i[ADDR_WIDTH+1:0];
                        req_di  <= dmem_di_i;
                        req_f3  <= dmem_func3_i;
                        req_re  <= dmem_re_i;
                        req_we  <= dmem_we_i;
                        cnt     <= CNT_INIT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= DONE;
                        if (req_err) begin
                            dmem_do_o <= '0;
                            err_o     <= 1'b1;
                        end else if (req_re) begin
                            dmem_do_o <= ld_val;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stall_o = resetn_i &
                     ((state == BUSY) |
                      ((state == IDLE) & (dmem_re_i | dmem_we_i)));

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Scoreboard bench for rv32i_dmem_responder.
// A byte-addressed reference memory predicts every completed access.
module tb_rv32i_dmem_responder;

    localparam int AW = 10;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        re;
    logic        we;
    logic [31:0] add;
    logic [31:0] di;
    logic [2:0]  f3;
    logic [31:0] dout;
    logic        stall;
    logic        err;

    always #5 clk = ~clk;

    rv32i_dmem_responder #(
        .ADDR_WIDTH (AW),
        .WAIT_STATES(WS)
    ) dut (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .dmem_re_i   (re),
        .dmem_we_i   (we),
        .dmem_add_i  (add),
        .dmem_di_i   (di),
        .dmem_func3_i(f3),
        .dmem_do_o   (dout),
        .stall_o     (stall),
        .err_o       (err)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mm[int];
    logic [31:0] last_do;
    int          checks = 0;
    int          passes = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic exp_t model(bit r, bit w, logic [31:0] a,
                                   logic [31:0] d, logic [2:0] f);
        exp_t   e;
        int     size;
        int     base;
        bit     ok;
        longint v;
        size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        base = int'(a[AW+1:0]);
        ok = !(r && w);
        if (w) ok = ok && (f <= 3'd2);
        if (r) ok = ok && (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        ok = ok && ((base % size) == 0);
        if (!ok) begin
            last_do = 32'd0;
        end else if (w) begin
            for (int i = 0; i < size; i++) mm[base + i] = d[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(mm[base + i]) << (8 * i);
            if (f < 3'd4 && size < 4 && v[8*size-1]) v -= longint'(1) << (8 * size);
            last_do = 32'(v);
        end
        e.err  = !ok;
        e.data = last_do;
        return e;
    endfunction

    // Drive one access from its IDLE cycle, return in the next IDLE cycle.
    task automatic issue(bit r, bit w, logic [31:0] a, logic [31:0] d,
                         logic [2:0] f, bit hold = 1'b0);
        int n;
        q.push_back(model(r, w, a, d, f));
        re = r; we = w; add = a; di = d; f3 = f;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (stall && n < 20);
        if (stall) begin
            checks++;
            $display("FAIL access_timeout: stall_o high after %0d cycles, required low", n);
        end
        if (!hold) begin
            re = 1'($urandom); we = 1'($urandom);
            add = $urandom; di = $urandom; f3 = 3'($urandom);
        end
        @(posedge clk); #1;
        if (!hold) begin
            re = 1'b0; we = 1'b0;
        end
    endtask

    bit          prev_stall = 1'b0;
    int          run = 0;
    bit          hold_pend = 1'b0;
    logic [31:0] hold_val;

    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            prev_stall = 1'b0;
            run = 0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("do_hold", dout, hold_val);
                check("err_after_done", {31'd0, err}, 32'd0);
                hold_pend = 1'b0;
            end
            if (stall) begin
                run++;
            end else if (prev_stall) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got completion, required none");
                end else begin
                    e = q.pop_front();
                    check("stall_len", run, WS + 1);
                    check("err_o", {31'd0, err}, {31'd0, e.err});
                    check("dmem_do", dout, e.data);
                    hold_val = e.data;
                    hold_pend = 1'b1;
                end
                run = 0;
            end
            prev_stall = stall;
        end
    end

    initial begin
        logic [7:0]  pat;
        logic [31:0] a;
        logic [2:0]  f;
        int          k;
        resetn = 1'b0; re = 1'b0; we = 1'b0;
        add = '0; di = '0; f3 = '0; last_do = '0;
        #12;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_do", dout, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;

        issue(0, 1, 32'h40, 32'h11111111, 3'd2);
        issue(1, 0, 32'h40, 32'h0, 3'd2);
        re = 1'b0; we = 1'b1; add = 32'h40; di = 32'hDEADBEEF; f3 = 3'd2;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_do", dout, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        we = 1'b0;
        last_do = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        issue(1, 0, 32'h40, 32'h0, 3'd2);

        issue(0, 1, 32'h10, 32'h12345678, 3'd2);
        issue(1, 0, 32'h10, 32'h0, 3'd2);

        issue(0, 1, 32'h13, 32'h000000AB, 3'd0);
        issue(1, 0, 32'h10, 32'h0, 3'd2);
        issue(1, 0, 32'h13, 32'h0, 3'd0);
        issue(1, 0, 32'h13, 32'h0, 3'd4);
        issue(1, 0, 32'h12, 32'h0, 3'd1);
        issue(1, 0, 32'h12, 32'h0, 3'd5);

        issue(1, 0, 32'h11, 32'h0, 3'd2);
        issue(0, 1, 32'h13, 32'h0000FFFF, 3'd1);
        issue(1, 0, 32'h10, 32'h0, 3'd2);
        issue(1, 0, 32'h10, 32'h0, 3'd7);

        issue(0, 1, 32'h1010, 32'hCAFEF00D, 3'd2);
        issue(1, 0, 32'h0010, 32'h0, 3'd2);
        issue(1, 1, 32'h10, 32'h0BADF00D, 3'd2);
        issue(1, 0, 32'h10, 32'h0, 3'd2);

        pat = '0;
        fork
            begin
                issue(1, 0, 32'h10, 32'h0, 3'd2, 1'b1);
                issue(1, 0, 32'h40, 32'h0, 3'd2);
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    pat = {pat[6:0], stall};
                end
            end
        join
        check("b2b_stall_pattern", {24'd0, pat}, 32'h000000EE);

        for (int w = 0; w < 16; w++) begin
            issue(0, 1, 32'h100 + 32'(4 * w), $urandom, 3'd2);
        end
        for (int i = 0; i < 150; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63)) +
                (32'($urandom_range(0, 3)) << 12);
            f = 3'($urandom_range(0, 7));
            k = $urandom_range(0, 9);
            if (k < 5) issue(1, 0, a, $urandom, f);
            else if (k < 9) issue(0, 1, a, $urandom, f);
            else issue(1, 1, a, $urandom, f);
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
